block_aligner66: RTL
====================

Name: block_aligner66

Overview:
- Sits directly downstream of the 33-way header seeker in the Aurora 64b/66b RX recovery path.
- Consumes the gearbox window stream together with the seeker's `block_offset`.
- Extracts complete 66b blocks (2b header + 64b payload) at the chosen offset and qualifies them through a hunt/verify/lock state machine with hysteresis.
- Emits one aligned block per valid buffer beat, plus a sync flag for the downstream descrambler.

Parameters:
- LOCK_CNT, 32, consecutive valid headers in VERIFY required to enter LOCKED (2..63).
- BAD_MAX, 16, invalid headers within one monitor window that drop LOCKED back to HUNT (1..63).
- MON_WIN, 64, blocks per monitor window in LOCKED; bad counter clears at window end (power of two, 16..256).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- gbox_buffer  in  194  complete gearbox buffer
- gbox_cnt  in  6  gearbox view window index (0..63)
- buffer_dv  in  1  gbox_buffer/gbox_cnt valid this cycle
- block_offset  in  7  seeker's header offset (valid 0..65)
- blk_data_o  out  64  aligned payload
- blk_hdr_o  out  2  aligned header
- blk_valid_o  out  1  one-cycle strobe, blk_data_o/blk_hdr_o valid
- blk_sync_o  out  1  high while state is LOCKED
- align_offset_o  out  7  offset currently in use

Behaviour:
- Clocking and reset: single clock domain, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: all outputs 0, state HUNT, all counters 0, prev-window register 0.
- Window: on buffer_dv, win = gbox_buffer[193-gbox_cnt -: 67]. Register prev_win <= win. Concat cat[133:0] = {prev_win, win}, formed with the pre-update prev_win.
- Extraction: hdr = cat[off+68 -: 2], data = cat[off+66 -: 64], where off = align_offset_o (held register).
- Output timing:
  - blk_valid_o asserts exactly 1 cycle after each buffer_dv.
  - No valid output on the first buffer_dv after reset (prev_win empty).
  - No output while off > 65.
- Header check: hdr is valid iff 2'b01 or 2'b10.
- State machine:
  - HUNT:
    - On each buffer_dv, load align_offset_o <= block_offset, clear good_cnt.
    - If block_offset <= 65, go to VERIFY; otherwise stay in HUNT.
  - VERIFY:
    - Per block: a valid header increments good_cnt.
    - An invalid header goes to HUNT and clears good_cnt.
    - good_cnt reaching LOCK_CNT goes to LOCKED and clears counters.
    - block_offset changes are ignored.
  - LOCKED:
    - blk_sync_o = 1.
    - Per block: blk_cnt increments; an invalid header increments bad_cnt.
    - bad_cnt reaching BAD_MAX goes to HUNT in the same cycle; blk_sync_o drops the next cycle.
    - At blk_cnt wrap (MON_WIN blocks), bad_cnt clears.
    - Simultaneous window wrap and BAD_MAX-th bad header: the transition to HUNT wins.
    - block_offset changes are ignored.
- Counter widths: good_cnt 6b; bad_cnt 6b, saturating; blk_cnt log2(MON_WIN) bits, wrapping.
- blk_valid_o and data pass through in every state, qualified by off <= 65. Consumers gate on blk_sync_o.
- A buffer_dv gap does not advance state; counters hold.
- Reset asserted mid-operation returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: BLOCK_ALIGNER66_STATS_EN.
- When defined, adds outputs:
  - hdr_err_cnt_o[15:0]: saturating count of invalid headers seen while LOCKED.
  - relock_cnt_o[7:0]: saturating count of LOCKED->HUNT transitions.
- Both reset to 0 and are cleared only by reset.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package rx_recovery_pkg:
  - header constants C_DATA_HEADER = 2'b01, C_CMD_HEADER = 2'b10
  - C_MAX_OFFSET = 65
  - enum align_state_t {HUNT, VERIFY, LOCKED}
- One natural sub-module, block_extract66: purely combinational slicing of {prev_win, win} at an offset. It is shared with future bit-slip/debug logic.
- The FSM and counters live in the top module.

Test Plan:
- Reset, then a stream of buffer_dv beats whose headers sit at offset 10 with block_offset = 10:
  - no blk_valid_o on beat 1;
  - blk_valid_o from beat 2;
  - blk_sync_o rises after the 32nd consecutive good header;
  - align_offset_o = 10.
- Locked at offset 10, inject 15 bad headers within 64 blocks: blk_sync_o stays 1, and bad_cnt clears at the window wrap.
- Locked, inject 16 bad headers within one window: state goes to HUNT, blk_sync_o = 0 the next cycle, and with STATS_EN relock_cnt_o = 1.
- In VERIFY after 20 good headers, inject one 2'b00 header: return to HUNT, good_cnt = 0, then relock requires a further 32 good headers.
- Hold block_offset = 70 in HUNT: no blk_valid_o, state stays HUNT. Change to 5: VERIFY entered and align_offset_o = 5.
- Assert rst_ni low mid-LOCKED between clock edges: all outputs 0 immediately. After release, the first beat yields no output.

Source files
------------

// File: rtl/rx_recovery_pkg.sv
// Shared definitions for the 64b/66b RX recovery path: sync header codes,
// offset limit and alignment state encoding.
package rx_recovery_pkg;

   localparam logic [1:0] C_DATA_HEADER = 2'b01;
   localparam logic [1:0] C_CMD_HEADER  = 2'b10;
   localparam logic [6:0] C_MAX_OFFSET  = 7'd65;

   typedef enum logic [1:0] {
      HUNT,
      VERIFY,
      LOCKED
   } align_state_t;

   function automatic logic hdr_is_valid(input logic [1:0] hdr);
      return (hdr == C_DATA_HEADER) || (hdr == C_CMD_HEADER);
   endfunction

endpackage

// File: rtl/block_extract66.sv
// Combinational slice of one 66b block (header + payload) out of the
// concatenated previous/current gearbox windows at a given bit offset.
module block_extract66 (
   input  logic [66:0] prev_win,
   input  logic [66:0] win,
   input  logic [6:0]  offset,
   output logic [1:0]  hdr,
   output logic [63:0] data
);

   logic [7:0] shamt;

   // Block LSB sits at cat[offset+3]; header occupies the two bits above the payload.
   assign shamt       = {1'b0, offset} + 8'd3;
   assign {hdr, data} = 66'({prev_win, win} >> shamt);

endmodule

// File: rtl/block_aligner66.sv
// 66b block aligner: extracts blocks at the seeker's offset and qualifies them
// with a hunt/verify/lock FSM. Optional stats via BLOCK_ALIGNER66_STATS_EN.
//
// state  | meaning
// HUNT   | load offset from seeker each beat, move on once it is in range
// VERIFY | count consecutive valid headers, any bad header returns to HUNT
// LOCKED | sync asserted, too many bad headers per monitor window drops to HUNT
module block_aligner66
   import rx_recovery_pkg::*;
#(
   parameter int LOCK_CNT = 32,
   parameter int BAD_MAX  = 16,
   parameter int MON_WIN  = 64
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [193:0] gbox_buffer,
   input  logic [5:0]   gbox_cnt,
   input  logic         buffer_dv,
   input  logic [6:0]   block_offset,
   output logic [63:0]  blk_data_o,
   output logic [1:0]   blk_hdr_o,
   output logic         blk_valid_o,
   output logic         blk_sync_o,
   output logic [6:0]   align_offset_o
`ifdef BLOCK_ALIGNER66_STATS_EN
  ,output logic [15:0]  hdr_err_cnt_o,
   output logic [7:0]   relock_cnt_o
`endif
);

   localparam int               BLK_W      = $clog2(MON_WIN);
   localparam logic [5:0]       LOCK_CNT_C = 6'(LOCK_CNT);
   localparam logic [5:0]       BAD_MAX_C  = 6'(BAD_MAX);
   localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(MON_WIN - 1);

   align_state_t     state;
   logic [66:0]      win;
   logic [66:0]      prev_win;
   logic             prev_vld;
   logic [1:0]       ext_hdr;
   logic [63:0]      ext_data;
   logic             hdr_ok;
   logic             blk_ok;
   logic [5:0]       good_cnt;
   logic [5:0]       bad_cnt;
   logic [5:0]       bad_next;
   logic [BLK_W-1:0] blk_cnt;

   // Window top bit is 193-gbox_cnt, so its LSB is 127-gbox_cnt.
   assign win = 67'(gbox_buffer >> (8'd127 - {2'b00, gbox_cnt}));

   block_extract66 u_extract (
      .prev_win (prev_win),
      .win      (win),
      .offset   (align_offset_o),
      .hdr      (ext_hdr),
      .data     (ext_data)
   );

   assign hdr_ok   = hdr_is_valid(ext_hdr);
   assign blk_ok   = buffer_dv && prev_vld && (align_offset_o <= C_MAX_OFFSET);
   assign bad_next = (bad_cnt == 6'h3f) ? bad_cnt : bad_cnt + {5'b0, ~hdr_ok};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state          <= HUNT;
         prev_win       <= '0;
         prev_vld       <= 1'b0;
         good_cnt       <= '0;
         bad_cnt        <= '0;
         blk_cnt        <= '0;
         blk_data_o     <= '0;
         blk_hdr_o      <= '0;
         blk_valid_o    <= 1'b0;
         blk_sync_o     <= 1'b0;
         align_offset_o <= '0;
`ifdef BLOCK_ALIGNER66_STATS_EN
         hdr_err_cnt_o  <= '0;
         relock_cnt_o   <= '0;
`endif
      end else begin
         blk_valid_o <= 1'b0;
         if (buffer_dv) begin
            prev_win <= win;
            prev_vld <= 1'b1;
            if (blk_ok) begin
               blk_valid_o <= 1'b1;
               blk_data_o  <= ext_data;
               blk_hdr_o   <= ext_hdr;
            end
            case (state)
               HUNT: begin
                  align_offset_o <= block_offset;
                  good_cnt       <= '0;
                  if (block_offset <= C_MAX_OFFSET) state <= VERIFY;
               end
               VERIFY: begin
                  if (blk_ok) begin
                     if (!hdr_ok) begin
                        state    <= HUNT;
                        good_cnt <= '0;
                     end else if (good_cnt + 6'd1 == LOCK_CNT_C) begin
                        state      <= LOCKED;
                        blk_sync_o <= 1'b1;
                        good_cnt   <= '0;
                        bad_cnt    <= '0;
                        blk_cnt    <= '0;
                     end else begin
                        good_cnt <= good_cnt + 6'd1;
                     end
                  end
               end
               LOCKED: begin
                  if (blk_ok) begin
`ifdef BLOCK_ALIGNER66_STATS_EN
                     if (!hdr_ok && hdr_err_cnt_o != 16'hffff)
                        hdr_err_cnt_o <= hdr_err_cnt_o + 16'd1;
`endif
                     // Losing lock takes priority over the window-end clear.
                     if (bad_next >= BAD_MAX_C) begin
                        state      <= HUNT;
                        blk_sync_o <= 1'b0;
                        bad_cnt    <= '0;
                        blk_cnt    <= '0;
`ifdef BLOCK_ALIGNER66_STATS_EN
                        if (relock_cnt_o != 8'hff) relock_cnt_o <= relock_cnt_o + 8'd1;
`endif
                     end else begin
                        blk_cnt <= blk_cnt + 1'b1;
                        bad_cnt <= (blk_cnt == BLK_LAST) ? 6'd0 : bad_next;
                     end
                  end
               end
               default: begin
                  state      <= HUNT;
                  blk_sync_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
